// File: rtl/dino_pkg.sv
// Shared encodings and widths for the runner game core.
package dino_pkg;

  localparam int COORD_W = 10;   // hCount / vCount width
  localparam int VEL_W   = 11;   // signed ypos / velocity width

  // One-hot game states; each bit drives one q_* output directly.
  typedef enum logic [2:0] {
    S_INI  = 3'b001,
    S_GAME = 3'b010,
    S_DONE = 3'b100
  } state_t;

  localparam logic [11:0] C_BLANK  = 12'h000;
  localparam logic [11:0] C_PLAYER = 12'hF00;
  localparam logic [11:0] C_OBST   = 12'h0F0;
  localparam logic [11:0] C_GROUND = 12'h888;
  localparam logic [11:0] C_BG     = 12'hFFF;

endpackage

// File: rtl/obstacle_lane.sv
// One obstacle lane: x position, leftward motion with wrap-around, and the
// per-lane player-overlap and pixel flags that the core reduces.
module obstacle_lane
  import dino_pkg::*;
#(
  parameter int X_W      = 11,
  parameter int INIT_X   = 640,
  parameter int SPAN     = 660,   // lanes * gap: wrap distance that keeps spacing
  parameter int SIZE     = 20,
  parameter int PLAYER_X = 200,
  parameter int GROUND_Y = 515
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               step,
  input  logic [X_W-1:0]     speed,
  input  logic [COORD_W-1:0] h_count,
  input  logic [COORD_W-1:0] v_count,
  output logic               wrap,
  output logic               hit,
  output logic               pix
);

  logic [X_W-1:0] x;
  logic [X_W-1:0] hx;

  // Wrap is judged on the pre-move position so the lane never goes negative.
  assign wrap = step && (x < speed);

  assign hit = (x < X_W'(PLAYER_X + SIZE)) && (X_W'(PLAYER_X) < x + X_W'(SIZE));

  assign hx  = X_W'(h_count);
  assign pix = (hx >= x) && (hx < x + X_W'(SIZE)) &&
               (v_count >= COORD_W'(GROUND_Y - SIZE)) && (v_count < COORD_W'(GROUND_Y));

  // Lane position: reload on reset/new game, move (or wrap) on each game step.
  always_ff @(posedge clk) begin
    if (rst || init)
      x <= X_W'(INIT_X);
    else if (step)
      x <= wrap ? x + X_W'(SPAN) - speed : x - speed;
  end

endmodule

// File: rtl/dino_runner_core.sv
// Runner game core: FSM, jump physics, obstacle lanes, scoring, speed levels
// and registered pixel colour for the VGA path.
module dino_runner_core
  import dino_pkg::*;
#(
  parameter int NUM_OBST   = 3,
  parameter int SCORE_W    = 16,
  parameter int SCREEN_W   = 640,
  parameter int GROUND_Y   = 515,
  parameter int PLAYER_X   = 200,
  parameter int SIZE       = 20,
  parameter int OBST_GAP   = 220,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int BASE_SPEED = 3,
  parameter int MAX_SPEED  = 8,
  parameter int LEVEL_PTS  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               up,
  input  logic               bright,
  input  logic [COORD_W-1:0] hCount,
  input  logic [COORD_W-1:0] vCount,
  output logic [11:0]        rgb,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               q_I,
  output logic               q_Game,
  output logic               q_Done
);

  // Lane x can start well past the screen edge, so it needs more than COORD_W.
  localparam int X_W = $clog2(SCREEN_W + NUM_OBST * OBST_GAP + SIZE + 1);

  localparam logic signed [VEL_W-1:0] GY = VEL_W'(GROUND_Y);
  localparam logic signed [VEL_W-1:0] SZ = VEL_W'(SIZE);
  localparam logic signed [VEL_W-1:0] JV = VEL_W'(JUMP_V);
  localparam logic signed [VEL_W-1:0] GR = VEL_W'(GRAVITY);

  state_t                    state;
  logic signed [VEL_W-1:0]   ypos, vel, vel_j, y_sum, vs;
  logic [X_W-1:0]            speed, speed_next;
  logic [SCORE_W:0]          score_sum;
  logic [SCORE_W-1:0]        score_next;
  logic [3:0]                wrap_cnt;
  logic [31:0]               lvl_spd;
  logic [NUM_OBST-1:0]       lane_wrap, lane_hit, lane_pix;
  logic                      y_hit, collide, start, step, player_pix;

  assign q_I    = state[0];
  assign q_Game = state[1];
  assign q_Done = state[2];

  assign start   = (state == S_INI) && up;
  assign y_hit   = (ypos - SZ < GY) && (GY - SZ < ypos);
  assign collide = (|lane_hit) && y_hit;
  // A colliding tick freezes motion, so lanes only step when no hit is present.
  assign step    = (state == S_GAME) && tick && !collide;

  for (genvar i = 0; i < NUM_OBST; i++) begin : g_lane
    obstacle_lane #(
      .X_W      (X_W),
      .INIT_X   (SCREEN_W + i * OBST_GAP),
      .SPAN     (NUM_OBST * OBST_GAP),
      .SIZE     (SIZE),
      .PLAYER_X (PLAYER_X),
      .GROUND_Y (GROUND_Y)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .init    (start),
      .step    (step),
      .speed   (speed),
      .h_count (hCount),
      .v_count (vCount),
      .wrap    (lane_wrap[i]),
      .hit     (lane_hit[i]),
      .pix     (lane_pix[i])
    );
  end

  // Number of lanes wrapping this tick = points earned.
  always_comb begin
    wrap_cnt = '0;
    for (int i = 0; i < NUM_OBST; i++)
      wrap_cnt = wrap_cnt + 4'(lane_wrap[i]);
  end

  // Next-tick physics, saturating score and the speed level derived from it.
  always_comb begin
    vel_j      = (up && ypos == GY) ? -JV : vel;
    y_sum      = ypos + vel_j;
    score_sum  = {1'b0, score} + (SCORE_W + 1)'(wrap_cnt);
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    lvl_spd    = 32'(BASE_SPEED) + 32'(score_next) / 32'(LEVEL_PTS);
    speed_next = (lvl_spd > 32'(MAX_SPEED)) ? X_W'(MAX_SPEED) : X_W'(lvl_spd);
  end

  // Game FSM together with all game-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INI;
      score      <= '0;
      high_score <= '0;
      ypos       <= GY;
      vel        <= '0;
      speed      <= X_W'(BASE_SPEED);
    end else begin
      case (state)
        S_INI: if (up) begin
          state <= S_GAME;
          score <= '0;
          ypos  <= GY;
          vel   <= '0;
          speed <= X_W'(BASE_SPEED);
        end
        S_GAME: if (tick) begin
          if (collide) begin
            state <= S_DONE;
            if (score > high_score) high_score <= score;
          end else begin
            if (y_sum >= GY) begin
              ypos <= GY;
              vel  <= '0;
            end else begin
              ypos <= y_sum;
              vel  <= vel_j + GR;
            end
            score <= score_next;
            speed <= speed_next;
          end
        end
        S_DONE: if (up) state <= S_INI;
        default: state <= S_INI;
      endcase
    end
  end

  assign vs         = {1'b0, vCount};
  assign player_pix = (hCount >= COORD_W'(PLAYER_X)) && (hCount < COORD_W'(PLAYER_X + SIZE)) &&
                      (vs >= ypos - SZ) && (vs < ypos);

  // Registered pixel colour, player over obstacle over ground over background.
  always_ff @(posedge clk) begin
    if (rst)                               rgb <= C_BLANK;
    else if (!bright)                      rgb <= C_BLANK;
    else if (player_pix)                   rgb <= C_PLAYER;
    else if (|lane_pix)                    rgb <= C_OBST;
    else if (vCount == COORD_W'(GROUND_Y)) rgb <= C_GROUND;
    else                                   rgb <= C_BG;
  end

endmodule

// File: tb/tb_dino_runner_core.sv
// Random-play bench for dino_runner_core with a behavioural game model.
module tb_dino_runner_core;

  localparam int SW = 6;          // small score width so saturation is reachable
  localparam int N  = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, tick, up, bright;
  logic [9:0]    hCount, vCount;
  logic [11:0]   rgb;
  logic [SW-1:0] score, high_score;
  logic          q_I, q_Game, q_Done;

  always #5 clk = ~clk;

  dino_runner_core #(.SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .bright(bright),
    .hCount(hCount), .vCount(vCount), .rgb(rgb), .score(score),
    .high_score(high_score), .q_I(q_I), .q_Game(q_Game), .q_Done(q_Done)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: 0=INI 1=GAME 2=DONE, positions in plain integers.
  int m_st, m_y, m_v, m_spd, m_sc, m_hs, m_rgb;
  int m_x [N];

  task automatic m_new_game();
    m_y = 515; m_v = 0; m_spd = 3; m_sc = 0;
    for (int i = 0; i < N; i++) m_x[i] = 640 + 220 * i;
  endtask

  function automatic int m_color(bit b, int h, int v);
    if (!b) return 0;
    if (h >= 200 && h < 220 && v >= m_y - 20 && v < m_y) return 'hF00;
    for (int i = 0; i < N; i++)
      if (h >= m_x[i] && h < m_x[i] + 20 && v >= 495 && v < 515) return 'h0F0;
    if (v == 515) return 'h888;
    return 'hFFF;
  endfunction

  function automatic bit m_collide();
    bit xo = 0;
    for (int i = 0; i < N; i++)
      if (m_x[i] < 220 && 200 < m_x[i] + 20) xo = 1;
    return xo && (m_y - 20 < 515) && (495 < m_y);
  endfunction

  task automatic m_clk(input bit r, input bit u, input bit t, input bit b, input int h, input int v);
    int n;
    if (r) begin
      m_st = 0; m_hs = 0; m_rgb = 0;
      m_new_game();
      return;
    end
    m_rgb = m_color(b, h, v);
    case (m_st)
      0: if (u) begin m_st = 1; m_new_game(); end
      1: if (t) begin
        if (m_collide()) begin
          m_st = 2;
          if (m_sc > m_hs) m_hs = m_sc;
        end else begin
          if (u && m_y == 515) m_v = -12;
          m_y = m_y + m_v;
          m_v = m_v + 1;
          if (m_y >= 515) begin m_y = 515; m_v = 0; end
          n = 0;
          for (int i = 0; i < N; i++) begin
            if (m_x[i] < m_spd) begin m_x[i] = m_x[i] + 660 - m_spd; n++; end
            else m_x[i] = m_x[i] - m_spd;
          end
          m_sc = (m_sc + n > SMAX) ? SMAX : m_sc + n;
          m_spd = (3 + m_sc / 10 > 8) ? 8 : 3 + m_sc / 10;
        end
      end
      default: if (u) m_st = 0;
    endcase
  endtask

  // Jump while an obstacle is 1..3 steps from the player box: clears it mid-air.
  function automatic bit want_jump();
    for (int i = 0; i < N; i++)
      if (m_x[i] >= 220 + m_spd && m_x[i] < 220 + 3 * m_spd) return 1;
    return 0;
  endfunction

  task automatic cyc(input bit r, input bit u, input bit t);
    int h, v;
    bit b;
    h = ($urandom % 2) ? int'($urandom_range(180, 240)) : int'($urandom % 1024);
    v = ($urandom % 2) ? int'($urandom_range(430, 520)) : int'($urandom % 1024);
    b = ($urandom % 8) != 0;
    rst = r; up = u; tick = t; bright = b;
    hCount = h[9:0]; vCount = v[9:0];
    @(posedge clk);
    m_clk(r, u, t, b, h, v);
    #1;
    chk("q_I", q_I, m_st == 0);
    chk("q_Game", q_Game, m_st == 1);
    chk("q_Done", q_Done, m_st == 2);
    chk("score", score, m_sc);
    chk("high_score", high_score, m_hs);
    chk("rgb", rgb, m_rgb);
  endtask

  initial begin
    int k;
    bit t, u;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst_qI", q_I, 1);
    chk("rst_score", score, 0);
    chk("rst_rgb", rgb, 0);

    // Free random play: random starts, occasional grounded jumps, airborne up.
    for (int i = 0; i < 1500; i++) begin
      t = ($urandom % 4) != 0;
      if (m_st == 1) u = (m_y == 515) ? (($urandom % 24) == 0) : (($urandom % 3) == 0);
      else           u = ($urandom % 4) == 0;
      cyc(0, u, t);
    end

    // Survival play until the score saturates, then keep going a while.
    k = 0;
    for (int i = 0; i < 9000; i++) begin
      if (m_sc == SMAX && m_st == 1) k++;
      if (k >= 300) break;
      t = ($urandom % 4) != 0;
      if (m_st != 1) u = 1;
      else if (m_y == 515) u = t && want_jump();
      else u = $urandom % 2;
      cyc(0, u, t);
    end
    chk("sat_score", score, SMAX);

    // Stop jumping: the next obstacle must end the game.
    for (int i = 0; i < 600 && m_st == 1; i++) cyc(0, 0, 1);
    chk("crash_done", q_Done, 1);
    chk("crash_high", high_score, SMAX);

    // Back to INI, start a game, then reset in the middle of it.
    cyc(0, 1, 1);
    chk("done_to_ini", q_I, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    chk("midrst_qI", q_I, 1);
    chk("midrst_high", high_score, 0);
    chk("midrst_rgb", rgb, 0);
    for (int i = 0; i < 20; i++) cyc(0, $urandom % 2, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
